// File: rtl/uart_parity_chk.sv
// UART receive-side parity checker: reassembles LSB-first data bits and checks the parity bit.
// done appears one cycle after the final bit is accepted; there is no backpressure, so bits must be qualified by the framer.
module uart_parity_chk #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 1,
    parameter int PARITY_TYPE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 par_valid,
    input  logic                 par_in,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_err
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic             ODD      = (PARITY_TYPE != 0);
    localparam logic             HAS_PAR  = (PARITY_EN != 0);

    logic [1:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic             acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            acc        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_out   <= '0;
            parity_err <= 1'b0;
        end else begin
            done <= 1'b0;
            // start overrides anything else in flight, including a final bit in the same cycle
            if (start) begin
                state      <= ST_DATA;
                bit_cnt    <= '0;
                acc        <= 1'b0;
                busy       <= 1'b1;
                data_out   <= '0;
                parity_err <= 1'b0;
            end else begin
                case (state)
                    ST_DATA: begin
                        if (bit_valid) begin
                            for (int i = 0; i < DATA_BITS; i++) begin
                                if (bit_cnt == CNT_W'(i)) begin
                                    data_out[i] <= bit_in;
                                end
                            end
                            acc <= acc ^ bit_in;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                if (HAS_PAR) begin
                                    state <= ST_PARITY;
                                end else begin
                                    state      <= ST_IDLE;
                                    busy       <= 1'b0;
                                    done       <= 1'b1;
                                    parity_err <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (par_valid) begin
                            // expected parity bit is the data XOR, inverted for odd parity
                            parity_err <= par_in ^ (acc ^ ODD);
                            state      <= ST_IDLE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_parity_chk.sv
// Scoreboard bench for uart_parity_chk: even, odd and no-parity instances driven by directed frames.
module tb_uart_parity_chk;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start     = '0;
    logic [2:0] bit_valid = '0;
    logic [2:0] bit_in    = '0;
    logic [2:0] par_valid = '0;
    logic [2:0] par_in    = '0;
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] perr;
    logic [7:0] dout [3];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        int         cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_parity_chk #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_TYPE(0)) u_even (
        .clk(clk), .rst(rst), .start(start[0]), .bit_valid(bit_valid[0]), .bit_in(bit_in[0]),
        .par_valid(par_valid[0]), .par_in(par_in[0]), .busy(busy[0]), .done(done[0]),
        .data_out(dout[0]), .parity_err(perr[0]));

    uart_parity_chk #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_TYPE(1)) u_odd (
        .clk(clk), .rst(rst), .start(start[1]), .bit_valid(bit_valid[1]), .bit_in(bit_in[1]),
        .par_valid(par_valid[1]), .par_in(par_in[1]), .busy(busy[1]), .done(done[1]),
        .data_out(dout[1]), .parity_err(perr[1]));

    uart_parity_chk #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_TYPE(0)) u_nopar (
        .clk(clk), .rst(rst), .start(start[2]), .bit_valid(bit_valid[2]), .bit_in(bit_in[2]),
        .par_valid(par_valid[2]), .par_in(par_in[2]), .busy(busy[2]), .done(done[2]),
        .data_out(dout[2]), .parity_err(perr[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic p);
        exp_t e;
        e.data = d;
        e.perr = p;
        e.cyc  = cyc;
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mon(input int k);
        exp_t e;
        bit   got;
        got = 1'b0;
        if (done[k] === 1'b1) begin
            compared++;
            case (k)
                0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
            endcase
            if (!got) begin
                mismatched++;
                $display("FAIL done_unexpected inst%0d cyc %0d: got done=1, required no done", k, cyc);
            end else if (dout[k] !== e.data || perr[k] !== e.perr || cyc != e.cyc) begin
                mismatched++;
                $display("FAIL done_frame inst%0d: got data=%02h perr=%b cyc=%0d, required data=%02h perr=%b cyc=%0d",
                         k, dout[k], perr[k], cyc, e.data, e.perr, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) mon(k);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int k);
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
    endtask

    task automatic do_bits(input int k, input logic [7:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid[k] = 1'b1;
            bit_in[k]    = val[i];
            tick();
        end
        bit_valid[k] = 1'b0;
        bit_in[k]    = 1'b0;
    endtask

    task automatic do_par(input int k, input logic p);
        par_valid[k] = 1'b1;
        par_in[k]    = p;
        tick();
        par_valid[k] = 1'b0;
        par_in[k]    = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_busy%0d", k), 32'(busy[k]), 32'd0);
            chk($sformatf("reset_done%0d", k), 32'(done[k]), 32'd0);
            chk($sformatf("reset_data%0d", k), 32'(dout[k]), 32'd0);
            chk($sformatf("reset_perr%0d", k), 32'(perr[k]), 32'd0);
        end
        rst = 1'b0;
        tick();

        // even, 0x17 (four ones), correct parity
        do_start(0);
        chk("busy_after_start", 32'(busy[0]), 32'd1);
        do_bits(0, 8'h17, 8);
        chk("busy_in_parity", 32'(busy[0]), 32'd1);
        do_par(0, 1'b0);
        push(0, 8'h17, 1'b0);
        chk("busy_after_done", 32'(busy[0]), 32'd0);
        tick();

        // even, 0x17, wrong parity; error held until next start
        do_start(0);
        do_bits(0, 8'h17, 8);
        do_par(0, 1'b1);
        push(0, 8'h17, 1'b1);
        repeat (3) tick();
        bit_valid[0] = 1'b1;
        bit_in[0]    = 1'b0;
        tick();
        bit_valid[0] = 1'b0;
        chk("err_held", 32'(perr[0]), 32'd1);
        chk("data_held_idle_bit", 32'(dout[0]), 32'h17);
        do_start(0);
        chk("err_cleared", 32'(perr[0]), 32'd0);
        chk("data_cleared", 32'(dout[0]), 32'd0);

        // odd, 0x0F: par 1 is correct, par 0 is an error
        do_start(1);
        do_bits(1, 8'h0F, 8);
        do_par(1, 1'b1);
        push(1, 8'h0F, 1'b0);
        tick();
        do_start(1);
        do_bits(1, 8'h0F, 8);
        do_par(1, 1'b0);
        push(1, 8'h0F, 1'b1);
        tick();

        // restart after four bits: only the second frame completes
        do_start(0);
        do_bits(0, 8'hFF, 4);
        do_start(0);
        do_bits(0, 8'h00, 8);
        do_par(0, 1'b0);
        push(0, 8'h00, 1'b0);
        tick();

        // start with bit_valid in the same cycle discards that bit
        start[0] = 1'b1; bit_valid[0] = 1'b1; bit_in[0] = 1'b1;
        tick();
        start[0] = 1'b0; bit_valid[0] = 1'b0; bit_in[0] = 1'b0;
        do_bits(0, 8'h55, 8);
        do_par(0, 1'b0);
        push(0, 8'h55, 1'b0);
        tick();

        // start together with the final par_valid: no done, no error update
        do_start(0);
        do_bits(0, 8'h17, 8);
        start[0] = 1'b1; par_valid[0] = 1'b1; par_in[0] = 1'b1;
        tick();
        start[0] = 1'b0; par_valid[0] = 1'b0; par_in[0] = 1'b0;
        chk("start_par_busy", 32'(busy[0]), 32'd1);
        chk("start_par_perr", 32'(perr[0]), 32'd0);
        do_bits(0, 8'h03, 8);
        do_par(0, 1'b1);
        push(0, 8'h03, 1'b1);
        tick();

        // reset mid-frame after five bits
        do_start(0);
        do_bits(0, 8'hFF, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_data", 32'(dout[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);
        tick();
        do_start(0);
        do_bits(0, 8'hA9, 2);
        par_valid[0] = 1'b1; par_in[0] = 1'b1;
        do_bits(0, 8'hA9 >> 2, 1);
        par_valid[0] = 1'b0; par_in[0] = 1'b0;
        chk("par_ignored_in_data", 32'(busy[0]), 32'd1);
        do_bits(0, 8'hA9 >> 3, 5);
        do_bits(0, 8'h00, 1);
        chk("bit_ignored_in_parity", 32'(dout[0]), 32'hA9);
        do_par(0, 1'b0);
        push(0, 8'hA9, 1'b0);
        tick();

        // no parity: done straight after the eighth bit; par_valid in idle does nothing
        do_start(2);
        do_bits(2, 8'hBD, 8);
        push(2, 8'hBD, 1'b0);
        chk("nopar_busy", 32'(busy[2]), 32'd0);
        tick();
        do_par(2, 1'b1);
        tick();
        do_par(2, 1'b0);
        repeat (4) tick();
        chk("nopar_data_held", 32'(dout[2]), 32'hBD);

        repeat (4) tick();
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
